vdc_pixel_serializer: RTL

- Next-generation VDC pixel output stage: converts per-column character/bitmap byte plus attribute byte into a serial RGBI pixel stream.
- Generalised over the 8-pixel fixed shifter:
  - programmable character total/displayed width (1–16 pixels)
  - double-pixel mode
  - full cursor modes with cursor line window
  - registered output
- Sits between the VDC fetch/timing logic (column strobes, latched screen/attr/char data) and the video output mux.

---
 rtl/vdc_pixel_serializer.sv | 279 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/vdc_pixel_serializer.sv
// -----------------------------------------------------------------------------
// vdc_pixel_serializer
//
// VDC pixel output stage. On each column strobe it latches the character or
// bitmap byte together with the attribute byte and register settings, then
// emits one RGBI colour per pixel period on a registered output.
//
// Ports
//   clk, reset      system clock, synchronous active-high reset
//   enable          pixel clock enable; no state moves while low
//   newCol          column strobe (only acts together with enable)
//   visible[1:0]    [1] active display area, [0] border area
//   line            raster line inside the character row
//   blink           blink phase per blink rate
//   crs_hit         column address equals cursor address
//   chardata, attr  column data, valid with newCol
//   reg_cth/cdh     character total / displayed width minus one
//   reg_dbl         double-pixel mode
//   reg_cm          cursor mode: 0 solid, 1 off, 2 fast blink, 3 slow blink
//   reg_cs/ce/ul    cursor start / end line, underline line
//   reg_cbrate      character blink rate select
//   reg_text        bitmap mode, reg_atr attribute enable,
//   reg_semi        semigraphics, reg_rvs global reverse
//   reg_fg/bg       default colours
//   rgbi            registered pixel colour
//   reg_hss         (VDC_HSCROLL_EN only) horizontal fine-scroll delay
//
// Optional feature: define VDC_HSCROLL_EN to add reg_hss and a pixel delay
// line in front of the output register.
//
// Parameter notes: CW_BITS must be at least 3 (a column holds 8 data bits);
// BLINK_SEL must be at least 1 (cursor modes use blink[0] and blink[1]).
// -----------------------------------------------------------------------------
module vdc_pixel_serializer #(
  parameter int CW_BITS   = 4,
  parameter int BLINK_SEL = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               newCol,
  input  logic [1:0]         visible,
  input  logic [4:0]         line,
  input  logic [BLINK_SEL:0] blink,
  input  logic               crs_hit,
  input  logic [7:0]         chardata,
  input  logic [7:0]         attr,
  input  logic [CW_BITS-1:0] reg_cth,
  input  logic [CW_BITS-1:0] reg_cdh,
  input  logic               reg_dbl,
  input  logic [1:0]         reg_cm,
  input  logic [4:0]         reg_cs,
  input  logic [4:0]         reg_ce,
  input  logic [4:0]         reg_ul,
  input  logic               reg_cbrate,
  input  logic               reg_text,
  input  logic               reg_atr,
  input  logic               reg_semi,
  input  logic               reg_rvs,
  input  logic [3:0]         reg_fg,
  input  logic [3:0]         reg_bg,
`ifdef VDC_HSCROLL_EN
  input  logic [CW_BITS-1:0] reg_hss,
`endif
  output logic [3:0]         rgbi
);

  localparam logic [CW_BITS-1:0] LAST_BIT_MAX = CW_BITS'(7);

  // Latched column state
  logic [7:0]         r_data;
  logic [CW_BITS-1:0] r_px;
  logic               r_half;
  logic [CW_BITS-1:0] r_cth;
  logic [CW_BITS-1:0] r_cdh;
  logic               r_dbl;
  logic               r_semi;
  logic               r_act;
  logic               r_win;
  logic [2:0]         r_ca;
  logic [3:0]         r_fg;
  logic [3:0]         r_bg;
  logic [3:0]         r_rgbi;

  // The border bit only matters upstream; a non-active column shows bg.
  logic w_unused_border;
  assign w_unused_border = visible[0];

  logic w_load;
  assign w_load = enable & newCol;

  // ---------------------------------------------------------------------------
  // Values that would be latched by a column load this cycle
  // ---------------------------------------------------------------------------
  logic [2:0] w_ld_ca;
  logic [7:0] w_ld_data;
  logic [3:0] w_ld_fg;
  logic [3:0] w_ld_bg;
  logic       w_ld_win;

  always_comb begin
    w_ld_ca  = (visible[1] & ~reg_text & reg_atr) ? attr[6:4] : 3'b000;
    w_ld_fg  = reg_atr ? attr[3:0] : reg_fg;
    w_ld_bg  = (visible[1] & reg_text & reg_atr) ? attr[7:4] : reg_bg;
    // cs > ce gives an empty window (no wrap-around)
    w_ld_win = crs_hit & (line >= reg_cs) & (line <= reg_ce);
    // Blink blanking wins over underline
    if (!visible[1])
      w_ld_data = 8'h00;
    else if (w_ld_ca[0] & blink[reg_cbrate])
      w_ld_data = 8'h00;
    else if (w_ld_ca[1] & (line == reg_ul))
      w_ld_data = 8'hFF;
    else
      w_ld_data = chardata;
  end

  // ---------------------------------------------------------------------------
  // Column view for the pixel produced this cycle. On a load the incoming
  // column is used directly so its first pixel reaches rgbi one enable cycle
  // after the strobe, and an early strobe drops the rest of the old column.
  // ---------------------------------------------------------------------------
  logic [7:0]         w_v_data;
  logic [CW_BITS-1:0] w_v_px;
  logic               w_v_half;
  logic [CW_BITS-1:0] w_v_cth;
  logic [CW_BITS-1:0] w_v_cdh;
  logic               w_v_dbl;
  logic               w_v_semi;
  logic               w_v_act;
  logic               w_v_win;
  logic [2:0]         w_v_ca;
  logic [3:0]         w_v_fg;
  logic [3:0]         w_v_bg;

  always_comb begin
    if (w_load) begin
      w_v_data = w_ld_data;
      w_v_px   = '0;
      w_v_half = 1'b0;
      w_v_cth  = reg_cth;
      w_v_cdh  = reg_cdh;
      w_v_dbl  = reg_dbl;
      w_v_semi = reg_semi;
      w_v_act  = visible[1];
      w_v_win  = w_ld_win;
      w_v_ca   = w_ld_ca;
      w_v_fg   = w_ld_fg;
      w_v_bg   = w_ld_bg;
    end else begin
      w_v_data = r_data;
      w_v_px   = r_px;
      w_v_half = r_half;
      w_v_cth  = r_cth;
      w_v_cdh  = r_cdh;
      w_v_dbl  = r_dbl;
      w_v_semi = r_semi;
      w_v_act  = r_act;
      w_v_win  = r_win;
      w_v_ca   = r_ca;
      w_v_fg   = r_fg;
      w_v_bg   = r_bg;
    end
  end

  // ---------------------------------------------------------------------------
  // Pixel generation and pixel-counter advance
  // ---------------------------------------------------------------------------
  logic [2:0]         w_last;
  logic               w_raw;
  logic               w_gate;
  logic               w_pix;
  logic [3:0]         w_color;
  logic [CW_BITS-1:0] w_nx_px;
  logic               w_nx_half;

  always_comb begin
    // Index of the last data bit shown; columns wider than 8 pad after it
    w_last = (w_v_cdh > LAST_BIT_MAX) ? 3'd7 : w_v_cdh[2:0];
    if (w_v_px <= CW_BITS'(w_last))
      w_raw = w_v_data[3'd7 - w_v_px[2:0]];
    else
      w_raw = w_v_semi & w_v_data[3'd7 - w_last];

    // Cursor mode and reverse act immediately, not at the next column
    case (reg_cm)
      2'd0:    w_gate = 1'b1;
      2'd1:    w_gate = 1'b0;
      2'd2:    w_gate = blink[0];
      default: w_gate = blink[1];
    endcase

    w_pix   = w_v_act & (w_raw ^ reg_rvs ^ w_v_ca[2] ^ (w_v_win & w_gate));
    w_color = w_pix ? w_v_fg : w_v_bg;

    // Double-pixel mode holds each pixel for two enable cycles
    if (w_v_dbl & ~w_v_half) begin
      w_nx_px   = w_v_px;
      w_nx_half = 1'b1;
    end else begin
      w_nx_half = 1'b0;
      w_nx_px   = (w_v_px < w_v_cth) ? (w_v_px + CW_BITS'(1)) : w_v_px;
    end
  end

  // ---------------------------------------------------------------------------
  // Output selection (optional fine-scroll delay line)
  // ---------------------------------------------------------------------------
  logic [3:0] w_out;

`ifdef VDC_HSCROLL_EN
  // Twice the column depth so a doubled-pixel delay still fits
  localparam int DL_DEPTH = 2 ** (CW_BITS + 1);

  logic [3:0]         r_dl [DL_DEPTH];
  logic [CW_BITS-1:0] w_hss;
  logic [CW_BITS:0]   w_dly;

  always_comb begin
    w_hss = (reg_hss > w_v_cth) ? w_v_cth : reg_hss;
    w_dly = w_v_dbl ? {w_hss, 1'b0} : {1'b0, w_hss};
    if (w_dly == '0)
      w_out = w_color;
    else
      w_out = r_dl[w_dly - (CW_BITS+1)'(1)];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DL_DEPTH; i++) r_dl[i] <= reg_bg;
    end else if (enable) begin
      r_dl[0] <= w_color;
      for (int i = 1; i < DL_DEPTH; i++) r_dl[i] <= r_dl[i-1];
    end
  end
`else
  assign w_out = w_color;
`endif

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data <= 8'h00;
      r_px   <= '0;
      r_half <= 1'b0;
      r_cth  <= '0;
      r_cdh  <= '0;
      r_dbl  <= 1'b0;
      r_semi <= 1'b0;
      r_act  <= 1'b0;
      r_win  <= 1'b0;
      r_ca   <= 3'b000;
      r_fg   <= 4'h0;
      r_bg   <= 4'h0;
      r_rgbi <= 4'h0;
    end else if (enable) begin
      r_px   <= w_nx_px;
      r_half <= w_nx_half;
      r_rgbi <= w_out;
      if (w_load) begin
        r_data <= w_ld_data;
        r_cth  <= reg_cth;
        r_cdh  <= reg_cdh;
        r_dbl  <= reg_dbl;
        r_semi <= reg_semi;
        r_act  <= visible[1];
        r_win  <= w_ld_win;
        r_ca   <= w_ld_ca;
        r_fg   <= w_ld_fg;
        r_bg   <= w_ld_bg;
      end
    end
  end

  assign rgbi = r_rgbi;

endmodule
